// File: rtl/eth_pkg.sv
// Shared constants, state encoding and MAC byte helper for the Ethernet receive parser.
package eth_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_DST,
        S_SRC,
        S_TYPE,
        S_PAYLOAD,
        S_PAD,
        S_FCS
    } eth_state_t;

    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [7:0]  ETH_PRE         = 8'h55;
    localparam logic [15:0] ETH_ARP         = 16'h0806;
    localparam logic [15:0] ETH_MAX_LEN     = 16'h05DC;
    localparam logic [10:0] ETH_ARP_LEN     = 11'd28;
    localparam logic [10:0] ETH_MIN_PAYLOAD = 11'd46;
    localparam logic [10:0] ETH_HDR_BYTES   = 11'd14;
    localparam logic [10:0] ETH_MAC_BYTES   = 11'd6;
    localparam logic [10:0] ETH_TYPE_BYTES  = ETH_HDR_BYTES - 11'd2 * ETH_MAC_BYTES;
    localparam logic [10:0] ETH_FCS_BYTES   = 11'd4;

    // remaining counts 6..1 down through the address; byte 0 (first on wire) is mac[47:40]
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [10:0] remaining);
        case (remaining)
            11'd6:   mac_byte = mac[47:40];
            11'd5:   mac_byte = mac[39:32];
            11'd4:   mac_byte = mac[31:24];
            11'd3:   mac_byte = mac[23:16];
            11'd2:   mac_byte = mac[15:8];
            default: mac_byte = mac[7:0];
        endcase
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/eth_rx_parser.sv
// Pops the raw receive byte stream, filters on destination MAC and streams payload bytes
// to the protocol layer with a last marker; header fields and frame counters are registered.
module eth_rx_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC = 48'h000A35000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_rd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_start,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_drop
);

    eth_state_t  state, state_next;
    logic [10:0] cnt, cnt_next;
    logic [10:0] len;
    logic [10:0] t_len, pad_len;
    logic [15:0] t_word;
    logic [47:0] src_shadow;
    logic [7:0]  t_hi;
    logic        seen55, mac_ok, bc_ok, match;
    logic        t_ok, last_byte, accept, drop_inc;

    assign out_data  = rx_data;
    assign match     = mac_ok | bc_ok;
    assign t_word    = {t_hi, rx_data};
    assign last_byte = (cnt == 11'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_HUNT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rx_rd      = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        accept     = 1'b0;
        drop_inc   = 1'b0;
        t_ok       = (t_word <= ETH_MAX_LEN) || (t_word == ETH_ARP);
        t_len      = (t_word <= ETH_MAX_LEN) ? t_word[10:0] : ETH_ARP_LEN;
        pad_len    = (len < ETH_MIN_PAYLOAD) ? ETH_MIN_PAYLOAD - len : '0;

        if ((state == S_PAYLOAD) && match) begin
            out_valid = ~rx_empty;
            rx_rd     = out_valid & out_ready;
            out_last  = out_valid & last_byte;
        end else begin
            rx_rd = ~rx_empty;
        end

        if (rx_rd) begin
            if (state != S_HUNT)
                cnt_next = cnt - 11'd1;
            unique case (state)
                S_HUNT: begin
                    if (seen55 && (rx_data == ETH_SFD)) begin
                        state_next = S_DST;
                        cnt_next   = ETH_MAC_BYTES;
                    end
                end
                S_DST: begin
                    if (last_byte) begin
                        state_next = S_SRC;
                        cnt_next   = ETH_MAC_BYTES;
                    end
                end
                S_SRC: begin
                    if (last_byte) begin
                        state_next = S_TYPE;
                        cnt_next   = ETH_TYPE_BYTES;
                    end
                end
                S_TYPE: begin
                    if (last_byte) begin
                        if (!t_ok) begin
                            drop_inc   = 1'b1;
                            state_next = S_HUNT;
                        end else begin
                            // Filtered frames still walk PAYLOAD/PAD/FCS so the byte count stays aligned
                            accept   = match;
                            drop_inc = ~match;
                            if (t_len == '0) begin
                                state_next = S_PAD;
                                cnt_next   = ETH_MIN_PAYLOAD;
                            end else begin
                                state_next = S_PAYLOAD;
                                cnt_next   = t_len;
                            end
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (last_byte) begin
                        if (pad_len != '0) begin
                            state_next = S_PAD;
                            cnt_next   = pad_len;
                        end else begin
                            state_next = S_FCS;
                            cnt_next   = ETH_FCS_BYTES;
                        end
                    end
                end
                S_PAD: begin
                    if (last_byte) begin
                        state_next = S_FCS;
                        cnt_next   = ETH_FCS_BYTES;
                    end
                end
                S_FCS: begin
                    if (last_byte)
                        state_next = S_HUNT;
                end
                default: state_next = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen55      <= 1'b0;
            mac_ok      <= 1'b0;
            bc_ok       <= 1'b0;
            src_shadow  <= '0;
            t_hi        <= '0;
            len         <= '0;
            frame_start <= 1'b0;
            src_mac     <= '0;
            ethertype   <= '0;
        end else begin
            frame_start <= accept;
            if (accept) begin
                src_mac   <= src_shadow;
                ethertype <= t_word;
            end
            if (rx_rd) begin
                case (state)
                    S_HUNT: begin
                        // 0xD5 clearing seen55 is harmless: with seen55 set it has just started a frame
                        seen55 <= (rx_data == ETH_PRE);
                        mac_ok <= 1'b1;
                        bc_ok  <= 1'b1;
                    end
                    S_DST: begin
                        mac_ok <= mac_ok & (rx_data == mac_byte(MAC, cnt));
                        bc_ok  <= bc_ok & (rx_data == 8'hFF);
                    end
                    S_SRC:  src_shadow <= {src_shadow[39:0], rx_data};
                    S_TYPE: begin
                        t_hi <= rx_data;
                        if (last_byte)
                            len <= t_len;
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter16 u_frames_ok (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .count (frames_ok)
    );

    sat_counter16 u_frames_drop (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (frames_drop)
    );

endmodule

// File: tb/tb_eth_rx_parser.sv
// Self-checking bench for eth_rx_parser: frames built from byte-level rules, a FIFO model
// feeds the DUT and the delivered payload is compared against per-frame expectations.
module tb_eth_rx_parser;

    localparam logic [47:0] MAC   = 48'h000A35000001;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        frame_start;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;

    eth_rx_parser #(.MAC(MAC)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_rd       (rx_rd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frame_start (frame_start),
        .src_mac     (src_mac),
        .ethertype   (ethertype),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  fifo[$];
    logic [7:0]  pl[$];
    logic [7:0]  got_data[$];
    logic        got_last[$];
    logic [7:0]  exp_data[$];
    logic        exp_last[$];
    int          fs_count = 0;
    int          exp_fs = 0;
    int          exp_ok = 0;
    int          exp_drop = 0;
    logic [47:0] exp_src = '0;
    logic [15:0] exp_type = '0;
    bit          ready_toggle = 1'b0;
    bit          stall_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One clock: drive at negedge, observe combinational outputs, pop the FIFO model at posedge.
    task automatic step();
        logic pop;
        @(negedge clk);
        out_ready = ready_toggle ? ~out_ready : 1'b1;
        rx_empty  = (fifo.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
        rx_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
        #1;
        if (rx_empty)
            check_eq("no_pop_when_empty", rx_rd, 0);
        if (out_valid && !out_ready)
            check_eq("no_pop_when_not_ready", rx_rd, 0);
        if (!out_valid)
            check_eq("last_needs_valid", out_last, 0);
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (frame_start)
            fs_count++;
        pop = rx_rd;
        @(posedge clk);
        if (pop && (fifo.size() != 0))
            void'(fifo.pop_front());
    endtask

    task automatic make_payload(input int n, input logic [7:0] base, input bit rnd);
        logic [7:0] b;
        pl.delete();
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            if (b == 8'h55)
                b = 8'h54;
            pl.push_back(b);
        end
    endtask

    // Queue a complete wire frame and record what the parser must do with it.
    task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] t);
        bit supported;
        int pad;
        for (int i = 0; i < 7; i++) fifo.push_back(8'h55);
        fifo.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) fifo.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fifo.push_back(src[i*8 +: 8]);
        fifo.push_back(t[15:8]);
        fifo.push_back(t[7:0]);
        foreach (pl[i]) fifo.push_back(pl[i]);
        pad = 46 - pl.size();
        for (int i = 0; i < pad; i++) fifo.push_back(8'h00);
        for (int i = 0; i < 4; i++) fifo.push_back(8'hA0 + 8'(i));
        supported = (t <= 16'd1500) || (t == 16'h0806);
        if (supported && ((dst == MAC) || (dst == BCAST))) begin
            exp_ok++;
            exp_fs++;
            exp_src  = src;
            exp_type = t;
            foreach (pl[i]) begin
                exp_data.push_back(pl[i]);
                exp_last.push_back(i == pl.size() - 1);
            end
        end else begin
            exp_drop++;
        end
    endtask

    task automatic push_random_frame();
        logic [47:0] dst, src;
        logic [15:0] t;
        int n;
        case ($urandom_range(0, 3))
            0, 2:    dst = MAC;
            1:       dst = BCAST;
            default: dst = {16'h0011, 32'($urandom)};
        endcase
        src = {16'h0200, 32'($urandom)};
        case ($urandom_range(0, 4))
            0: begin t = 16'h0806; n = 28; end
            1: begin t = 16'h0800; n = $urandom_range(0, 20); end
            2: begin t = 16'h0000; n = 0; end
            default: begin n = $urandom_range(1, 60); t = 16'(n); end
        endcase
        make_payload(n, 8'h00, 1'b1);
        push_frame(dst, src, t);
    endtask

    task automatic finish_scenario(input string tag);
        int k = 0;
        while ((fifo.size() != 0) && (k < 20000)) begin
            step();
            k++;
        end
        check_eq({tag, "_drained"}, fifo.size(), 0);
        repeat (3) step();
        check_eq({tag, "_count"}, got_data.size(), exp_data.size());
        for (int i = 0; (i < exp_data.size()) && (i < got_data.size()); i++) begin
            check_eq($sformatf("%s_data[%0d]", tag, i), got_data[i], exp_data[i]);
            check_eq($sformatf("%s_last[%0d]", tag, i), got_last[i], exp_last[i]);
        end
        check_eq({tag, "_frame_start"}, fs_count, exp_fs);
        check_eq({tag, "_frames_ok"}, frames_ok, exp_ok);
        check_eq({tag, "_frames_drop"}, frames_drop, exp_drop);
        check_eq({tag, "_src_mac"}, src_mac, exp_src);
        check_eq({tag, "_ethertype"}, ethertype, exp_type);
        got_data.delete();
        got_last.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset     = 1'b1;
        rx_empty  = 1'b1;
        rx_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_eq("rst_rx_rd", rx_rd, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_src_mac", src_mac, 0);
        check_eq("rst_ethertype", ethertype, 0);
        check_eq("rst_frames_ok", frames_ok, 0);
        check_eq("rst_frames_drop", frames_drop, 0);

        make_payload(28, 8'h00, 1'b0);
        push_frame(BCAST, 48'h020000000007, 16'h0806);
        finish_scenario("bcast_arp");

        pl = '{8'hAA, 8'hBB, 8'hCC};
        push_frame(MAC, 48'h020000000011, 16'h0003);
        finish_scenario("len3");
        make_payload(28, 8'h00, 1'b1);
        push_frame(MAC, 48'h020000000012, 16'h0806);
        finish_scenario("after_len3");

        make_payload(28, 8'h00, 1'b1);
        push_frame(48'h001122334455, 48'h020000000013, 16'h0806);
        finish_scenario("dst_mismatch");

        make_payload(20, 8'h00, 1'b1);
        push_frame(MAC, 48'h020000000014, 16'h0800);
        make_payload(28, 8'h40, 1'b0);
        push_frame(BCAST, 48'h020000000015, 16'h0806);
        finish_scenario("ipv4_then_arp");

        make_payload(10, 8'h00, 1'b1);
        push_frame(MAC, 48'h020000000016, 16'h05DD);
        make_payload(1500, 8'h00, 1'b1);
        push_frame(MAC, 48'h020000000017, 16'h05DC);
        make_payload(0, 8'h00, 1'b1);
        push_frame(BCAST, 48'h020000000018, 16'h0000);
        finish_scenario("len_bounds");

        ready_toggle = 1'b1;
        stall_en     = 1'b1;
        for (int f = 0; f < 12; f++)
            push_random_frame();
        finish_scenario("backpressure");

        ready_toggle = 1'b0;
        stall_en     = 1'b0;
        make_payload(40, 8'h00, 1'b1);
        push_frame(MAC, 48'h020000000019, 16'd40);
        k = 0;
        while ((got_data.size() < 5) && (k < 500)) begin
            step();
            k++;
        end
        check_eq("reached_mid_payload", got_data.size() >= 5, 1);
        reset = 1'b1;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_last", out_last, 0);
        check_eq("midrst_frame_start", frame_start, 0);
        check_eq("midrst_src_mac", src_mac, 0);
        check_eq("midrst_ethertype", ethertype, 0);
        check_eq("midrst_frames_ok", frames_ok, 0);
        check_eq("midrst_frames_drop", frames_drop, 0);
        got_data.delete();
        got_last.delete();
        exp_data.delete();
        exp_last.delete();
        fs_count = 0;
        exp_fs   = 0;
        exp_ok   = 0;
        exp_drop = 0;
        exp_src  = '0;
        exp_type = '0;
        repeat (2) step();
        reset = 1'b0;
        make_payload(30, 8'h00, 1'b1);
        push_frame(BCAST, 48'h02000000001A, 16'd30);
        finish_scenario("reset_resume");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
